// File: rtl/ha_pair_mul_pkg.sv
// Shared widths, approximation-mode encodings and controller states for the
// time-shared half-adder pair-row multiplier.
package ha_pair_mul_pkg;

  localparam int W     = 8;
  localparam int PW    = 2 * W;
  localparam int NPAIR = W / 2;
  localparam int TW    = 9;
  localparam int BW    = 7;
  localparam int MW    = 2 * (W - 1);

  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_OR    = 2'b01;
  localparam logic [1:0] MODE_ELIM  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ha_pair_row.sv
// Combinational reducer for one x bit-pair: folds rows y&x[2k] and y&x[2k+1]
// into a top vector t (weights 0..8) and a carry vector b (weights 2..8).
module ha_pair_row
  import ha_pair_mul_pkg::*;
(
  input  logic [W-1:0]  y,
  input  logic [1:0]    xp,
  input  logic [MW-1:0] mode,
  output logic [TW-1:0] t,
  output logic [BW-1:0] b
);

  logic       a;
  logic       c;
  logic       carry;
  logic [1:0] m;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    t     = '0;
    b     = '0;
    a     = 1'b0;
    c     = 1'b0;
    carry = 1'b0;
    m     = MODE_EXACT;
    t[0]  = y[0] & xp[0];
    b[6]  = y[7] & xp[1];
    for (int j = 1; j < W; j++) begin
      a = y[j] & xp[0];
      c = y[j-1] & xp[1];
      m = mode[2*j-1 -: 2];
      case (m)
        MODE_OR: begin
          t[j]  = a | c;
          carry = 1'b0;
        end
        MODE_ELIM: begin
          t[j]  = 1'b0;
          carry = 1'b0;
        end
        default: begin
          t[j]  = a ^ c;
          carry = a & c;
        end
      endcase
      // Column 7's carry has weight 8, which lives in t rather than b.
      if (j == W - 1) t[TW-1] = carry;
      else            b[j-1]  = carry;
    end
  end

endmodule

// File: rtl/ha_pair_mul_seq.sv
// Sequential 8x8 multiplier: one shared pair-row reducer walks the four x
// bit-pairs, shift-accumulating each pair value with per-pair column modes.
module ha_pair_mul_seq
  import ha_pair_mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_pair,
  input  logic [MW-1:0] cfg_mode,
  output logic          busy
);

  state_t        state;
  logic [1:0]    k;
  logic [W-1:0]  x_q;
  logic [W-1:0]  y_q;
  logic [PW-1:0] acc;
  logic [MW-1:0] mode_tab [NPAIR];

  logic [TW-1:0] t;
  logic [BW-1:0] b;
  logic [PW-1:0] pair_value;
  logic [PW-1:0] acc_next;

  ha_pair_row u_row (
    .y    (y_q),
    .xp   (x_q[{k, 1'b0} +: 2]),
    .mode (mode_tab[k]),
    .t    (t),
    .b    (b)
  );

  // b[i] carries weight i+2; the exact maximum 65025 fits, so no wrap handling.
  assign pair_value = PW'(t) + (PW'(b) << 2);
  assign acc_next   = acc + (pair_value << {k, 1'b0});

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      x_q       <= '0;
      y_q       <= '0;
      acc       <= '0;
      p         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      // NOTE: the mode table is reset on purpose: reset must restore exact multiplication.
      for (int i = 0; i < NPAIR; i++) mode_tab[i] <= MODE_EXACT == 2'b00 ? '0 : '0;
    end else begin
      if (cfg_we && state == IDLE) mode_tab[cfg_pair] <= cfg_mode;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q      <= x;
            y_q      <= y;
            acc      <= '0;
            k        <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_next;
          k   <= k + 2'd1;
          if (k == 2'(NPAIR - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            p         <= acc_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_pair_mul_seq.sv
// Self-checking bench for ha_pair_mul_seq: directed handshake/config/reset
// scenarios plus random operands against a column-sum reference model.
module tb_ha_pair_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  x = '0;
  logic [7:0]  y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] p;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_pair = '0;
  logic [13:0] cfg_mode = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int lat;
  int xv, yv;
  logic [13:0] tb_mode [4];

  always #5 clk = ~clk;

  ha_pair_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .cfg_we    (cfg_we),
    .cfg_pair  (cfg_pair),
    .cfg_mode  (cfg_mode),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: each column j of pair k contributes (a+c), (a|c) or 0 at weight j.
  function automatic int model_p(input int xa, input int ya);
    int sum = 0;
    for (int kk = 0; kk < 4; kk++) begin
      int x0  = (xa >> (2 * kk)) & 1;
      int x1  = (xa >> (2 * kk + 1)) & 1;
      int row = (ya & 1) * x0 + ((((ya >> 7) & 1) * x1) << 8);
      for (int j = 1; j < 8; j++) begin
        int a  = ((ya >> j) & 1) * x0;
        int c  = ((ya >> (j - 1)) & 1) * x1;
        int md = (tb_mode[kk] >> (2 * (j - 1))) & 3;
        case (md)
          1:       row += (a | c) << j;
          2:       row += 0;
          default: row += (a + c) << j;
        endcase
      end
      sum += row << (2 * kk);
    end
    return sum;
  endfunction

  task automatic cfg_write(input int pair, input logic [13:0] mode);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_pair = 2'(pair);
    cfg_mode = mode;
    @(negedge clk);
    cfg_we   = 1'b0;
    tb_mode[pair] = mode;
  endtask

  task automatic start_job(input int xa, input int ya);
    @(negedge clk);
    x        = 8'(xa);
    y        = 8'(ya);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    x        = 8'($urandom);
    y        = 8'($urandom);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      check("in_ready_low_while_busy", in_ready, 0);
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic finish_job(input string tag, input int exp);
    check({tag, "_valid"}, out_valid, 1);
    check(tag, p, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid, 0);
    check({tag, "_ready"}, in_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tb_mode[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Full-scale exact product with latency check.
    start_job(255, 255);
    check("busy_run", busy, 1);
    wait_done(lat);
    check("latency", lat, 4);
    finish_job("p_255x255", 65025);

    // Column-1 approximations on pair 0.
    start_job(3, 3);
    wait_done(lat);
    finish_job("p_3x3_exact", 9);
    cfg_write(0, 14'b01);
    start_job(3, 3);
    wait_done(lat);
    finish_job("p_3x3_or", 7);
    cfg_write(0, 14'b10);
    start_job(3, 3);
    wait_done(lat);
    finish_job("p_3x3_elim", 5);
    cfg_write(0, 14'b00);

    // Output held while consumer stalls.
    start_job(77, 201);
    wait_done(lat);
    check("stall_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_p", p, 77 * 201);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    finish_job("p_stall", 77 * 201);

    // Config write while busy is ignored.
    start_job(3, 3);
    cfg_we   = 1'b1;
    cfg_pair = 2'd0;
    cfg_mode = 14'b10;
    @(negedge clk);
    cfg_we   = 1'b0;
    wait_done(lat);
    finish_job("p_busy_cfg", 9);
    start_job(3, 3);
    wait_done(lat);
    finish_job("p_busy_cfg_next", 9);

    // Config write and accept in the same IDLE cycle: new job sees new mode.
    @(negedge clk);
    x        = 8'd3;
    y        = 8'd3;
    in_valid = 1'b1;
    cfg_we   = 1'b1;
    cfg_pair = 2'd0;
    cfg_mode = 14'b01;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    tb_mode[0] = 14'b01;
    wait_done(lat);
    finish_job("p_same_cycle_cfg", 7);

    // Reset during RUN k=2 aborts and restores exact config.
    start_job(255, 255);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tb_mode[i] = '0;
    check("abort_out_valid", out_valid, 0);
    check("abort_p", p, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    start_job(3, 3);
    wait_done(lat);
    finish_job("p_abort_cfg_exact", 9);
    start_job(200, 100);
    wait_done(lat);
    finish_job("p_200x100", 20000);

    // Random operands, exact.
    for (int n = 0; n < 1000; n++) begin
      xv = $urandom_range(0, 255);
      yv = $urandom_range(0, 255);
      start_job(xv, yv);
      wait_done(lat);
      finish_job("rand_exact", xv * yv);
    end

    // Reserved mode 11 everywhere behaves as exact.
    for (int i = 0; i < 4; i++) cfg_write(i, 14'h3FFF);
    for (int n = 0; n < 50; n++) begin
      xv = $urandom_range(0, 255);
      yv = $urandom_range(0, 255);
      start_job(xv, yv);
      wait_done(lat);
      finish_job("rand_mode11", xv * yv);
    end

    // Random approximation sweep against the reference model.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) cfg_write(i, 14'($urandom));
      xv = $urandom_range(0, 255);
      yv = $urandom_range(0, 255);
      start_job(xv, yv);
      wait_done(lat);
      finish_job("rand_approx", model_p(xv, yv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ha_pair_mul_seq.md
Name: ha_pair_mul_seq

Overview:
- Sequential unsigned 8x8 multiplier that time-shares one half-adder pair-row reducer across the four x bit-pairs.
- Each pair k covers x[2k] and x[2k+1] and produces a 9-bit top vector t and a 7-bit bottom vector b, exactly as the ha_array stage does.
- A controller iterates k=0..3 and shift-accumulates t and b into a 16-bit product.
- Per-pair, per-column approximation modes (exact HA / OR-only / eliminate) are run-time configurable, so one block sweeps the approximate-multiplier design space.

Parameters:
- NPAIR, 4, number of x bit-pairs (fixed for 8-bit x; not overridable in practice)
- W, 8, operand width
- PW, 16, product width (2*W)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept operands (high only in IDLE)
- x  in  8  multiplicand, sampled when in_valid&&in_ready
- y  in  8  multiplier, sampled when in_valid&&in_ready
- out_valid  out  1  product available
- out_ready  in  1  consumer accepts product
- p  out  16  accumulated (possibly approximate) product
- cfg_we  in  1  config write strobe
- cfg_pair  in  2  pair index k to configure
- cfg_mode  in  14  2-bit mode for columns j=1..7; column j uses bits [2j-1:2j-2]
- busy  out  1  state != IDLE

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk/rst, and all registers clear on it.
- Reset values: in_ready=1 (after reset, in IDLE), out_valid=0, p=0, busy=0, accumulator=0, k=0, all mode entries=00 (exact).
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE: on in_valid, latch x and y, clear acc, set k=0, go to RUN.
  - RUN: one pair per cycle, acc += pair_value(k) << 2k, k++. After k=3 go to DONE. RUN always lasts exactly 4 cycles.
  - DONE: out_valid=1 and p=acc, both held stable until out_ready. On the out_ready handshake go to IDLE and drop out_valid that same edge.
- Timing: latency from the accept edge to out_valid is 4 cycles. Minimum initiation interval is 6 cycles. There is no overlap of jobs.
- Pair row for pair k, column j (j=1..7), with a=y[j]&x[2k] and c=y[j-1]&x[2k+1]:
  - Mode 00: t[j]=a^c, b[j-1]=a&c.
  - Mode 01 (OR-only): t[j]=a|c, b[j-1]=0.
  - Mode 10 (eliminate): t[j]=0, b[j-1]=0.
  - Mode 11: reserved, treated as 00.
- Remaining pair-row bits:
  - t[0]=y[0]&x[2k].
  - t[8]=carry of column 7, which is the b-side carry of column 7 routed to t, weight 8.
  - b[6]=y[7]&x[2k+1].
  - b[i] has weight i+2, for i=0..5.
- pair_value = sum t[i]*2^i + sum b[i]*2^(i+2). With all modes 00 it equals y*{x[2k+1],x[2k]}.
- Width: exact maximum is 65025, which fits in 16 bits. Approximate modes never increase any column, so no overflow handling is needed. Accumulator is 16 bits, and wrap never occurs.
- Config writes:
  - Accepted only when busy=0. When busy=1, cfg_we is ignored silently.
  - A write overwrites the 14-bit entry for cfg_pair.
  - If cfg_we and the in_valid accept occur in the same IDLE cycle, the write lands that edge, and the new job uses the new config.
- Reset mid-operation aborts the job: FSM returns to IDLE, any partial result is discarded, and config returns to exact.
- Inputs x and y are don't-care outside the accept cycle.

Decomposition:
- Package ha_pair_mul_pkg holds:
  - mode encodings MODE_EXACT=2'b00, MODE_OR=2'b01, MODE_ELIM=2'b10
  - state enum {IDLE, RUN, DONE}
  - widths W, PW, NPAIR, TW=9, BW=7
- Sub-module ha_pair_row: purely combinational. Inputs are y[7:0], the x pair bits [1:0] and the 14-bit mode. Outputs are t[8:0] and b[6:0]. It is instantiated once and shared across k.

Test Plan:
- Reset, then x=255, y=255, all modes exact -> out_valid rises 4 cycles after accept; p=65025; in_ready=0 throughout.
- x=3, y=3, exact -> p=9. Then write cfg_pair=0 with col1 mode=01 -> p=7. Then col1 mode=10 -> p=5. Column 1 is cfg_mode[1:0].
- Hold out_ready=0 for 5 cycles in DONE -> p and out_valid stay stable and in_ready stays 0. Release out_ready -> IDLE next edge, in_ready=1.
- cfg_we asserted while busy with col1=10 for pair 0, job x=3, y=3 -> write ignored, p=9, and the next job also gives p=9.
- Assert rst during the RUN cycle k=2 -> next cycle out_valid=0, p=0, in_ready=1, config exact; the following job x=200, y=100 gives p=20000.
- Random 1000 operands with all modes exact -> p==x*y on every job. Mode 11 on all columns -> identical results.
